// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store engine.
//
// Takes the effective address from the ALU together with the store operand
// and the current rt value. It issues one Avalon-MM word transaction, which
// the slave may stall with waitrequest. For loads it returns aligned and
// extended data (LB/LBU/LH/LHU/LW/LWL/LWR). For stores it drives byte-lane
// writes (SB/SH/SW).
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   start               request strobe; mem_op/addr/store_data/rt_old valid
//   mem_op[3:0]         operation code (see Op* constants)
//   addr[31:0]          byte address
//   store_data[31:0]    rt value to store
//   rt_old[31:0]        current rt, merged by LWL/LWR
//   busy                high whenever the engine is not idle
//   done                one-cycle completion pulse
//   err                 one-cycle fault pulse, coincident with done
//   load_result[31:0]   last successfully loaded value
//   avm_*               Avalon-MM master (word-aligned, byteenable lanes)
//
// Parameter:
//   TIMEOUT_CYCLES      stalled REQ cycles before abort; 0 disables

module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [31:0] rt_old,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] load_result,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);

    localparam logic [3:0] OpLb  = 4'b0000;
    localparam logic [3:0] OpLbu = 4'b0001;
    localparam logic [3:0] OpLh  = 4'b0010;
    localparam logic [3:0] OpLhu = 4'b0011;
    localparam logic [3:0] OpLw  = 4'b0100;
    localparam logic [3:0] OpLwl = 4'b0101;
    localparam logic [3:0] OpLwr = 4'b0110;
    localparam logic [3:0] OpSb  = 4'b1000;
    localparam logic [3:0] OpSh  = 4'b1001;
    localparam logic [3:0] OpSw  = 4'b1010;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [1:0]  k_q, k_d;
    logic [31:0] rt_q, rt_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] load_q, load_d;
    logic [31:0] addr_q, addr_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] cnt_q, cnt_d;

    // Returns 1 for a defined opcode whose address satisfies its alignment.
    function automatic logic op_ok(input logic [3:0] op, input logic [1:0] k);
        logic ok;
        ok = 1'b0;
        case (op)
            OpLb, OpLbu, OpLwl, OpLwr, OpSb: ok = 1'b1;
            OpLh, OpLhu, OpSh:               ok = ~k[0];
            OpLw, OpSw:                      ok = (k == 2'd0);
            default:                         ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return op[3];
    endfunction

    // Aligns and extends the returned word. LWL/LWR keep the rt bytes that
    // the unaligned access does not cover.
    function automatic logic [31:0] align_load(input logic [3:0]  op,
                                               input logic [1:0]  k,
                                               input logic [31:0] w,
                                               input logic [31:0] rt);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        unique case (k)
            2'd0: b = w[7:0];
            2'd1: b = w[15:8];
            2'd2: b = w[23:16];
            2'd3: b = w[31:24];
        endcase
        h = k[1] ? w[31:16] : w[15:0];
        r = w;
        case (op)
            OpLb:  r = {{24{b[7]}}, b};
            OpLbu: r = {24'h0, b};
            OpLh:  r = {{16{h[15]}}, h};
            OpLhu: r = {16'h0, h};
            OpLwl: begin
                unique case (k)
                    2'd0: r = {w[7:0], rt[23:0]};
                    2'd1: r = {w[15:0], rt[15:0]};
                    2'd2: r = {w[23:0], rt[7:0]};
                    2'd3: r = w;
                endcase
            end
            OpLwr: begin
                unique case (k)
                    2'd0: r = w;
                    2'd1: r = {rt[31:24], w[31:8]};
                    2'd2: r = {rt[31:16], w[31:16]};
                    2'd3: r = {rt[31:8], w[31:24]};
                endcase
            end
            default: r = w;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        k_d     = k_q;
        rt_d    = rt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        load_d  = load_q;
        addr_d  = addr_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        cnt_d   = cnt_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    op_d = mem_op;
                    k_d  = addr[1:0];
                    rt_d = rt_old;
                    if (!op_ok(mem_op, addr[1:0])) begin
                        // Faults complete without touching the bus.
                        state_d = StDone;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = StReq;
                        addr_d  = {addr[31:2], 2'b00};
                        cnt_d   = 32'd0;
                        if (is_store(mem_op)) begin
                            wr_d = 1'b1;
                            case (mem_op)
                                OpSb: begin
                                    be_d    = 4'b0001 << addr[1:0];
                                    wdata_d = {4{store_data[7:0]}};
                                end
                                OpSh: begin
                                    be_d    = addr[1] ? 4'b1100 : 4'b0011;
                                    wdata_d = {2{store_data[15:0]}};
                                end
                                default: begin
                                    be_d    = 4'b1111;
                                    wdata_d = store_data;
                                end
                            endcase
                        end else begin
                            rd_d = 1'b1;
                            be_d = 4'b1111;
                        end
                    end
                end
            end

            StReq: begin
                if (!avm_waitrequest) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = StDone;
                    done_d  = 1'b1;
                    if (!is_store(op_q)) begin
                        load_d = align_load(op_q, k_q, avm_readdata, rt_q);
                    end
                end else if (TIMEOUT_CYCLES != 0) begin
                    if (cnt_q + 32'd1 == TIMEOUT_CYCLES) begin
                        // Abort: drop the request, keep load_result.
                        rd_d    = 1'b0;
                        wr_d    = 1'b0;
                        state_d = StDone;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
            end

            StDone: state_d = StIdle;

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            op_q    <= 4'h0;
            k_q     <= 2'd0;
            rt_q    <= 32'h0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            load_q  <= 32'h0;
            addr_q  <= 32'h0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            cnt_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            k_q     <= k_d;
            rt_q    <= rt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            load_q  <= load_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy           = (state_q != StIdle);
    assign done           = done_q;
    assign err            = err_q;
    assign load_result    = load_q;
    assign avm_address    = addr_q;
    assign avm_read       = rd_q;
    assign avm_write      = wr_q;
    assign avm_writedata  = wdata_q;
    assign avm_byteenable = be_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a stimulus process pushes expected
// completions, a slave model checks bus signals, a monitor checks completions.
module tb_mem_access_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  mem_op = 4'h0;
    logic [31:0] addr = 32'h0, store_data = 32'h0, rt_old = 32'h0;
    logic        busy, done, err, avm_read, avm_write;
    logic [31:0] load_result, avm_address, avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata = 32'h0;
    logic        avm_waitrequest = 1'b0;

    mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .mem_op(mem_op), .addr(addr),
        .store_data(store_data), .rt_old(rt_old), .busy(busy), .done(done), .err(err),
        .load_result(load_result), .avm_address(avm_address), .avm_read(avm_read),
        .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_byteenable(avm_byteenable), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int failed = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic [31:0] res;
        int          lat;
        int          start_cyc;
    } exp_t;
    exp_t exp_q[$];

    // Expectations for the bus side of the current transaction.
    logic        cur_bus = 1'b0, cur_is_load = 1'b0;
    logic [31:0] cur_addr = 32'h0, cur_wd = 32'h0, resp_data = 32'h0;
    logic [3:0]  cur_be = 4'h0;
    int          resp_wait = 0;
    int          wcnt = 0;
    logic [31:0] model_lr = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic model_legal(input logic [3:0] op, input int k);
        if (op inside {4'd0, 4'd1, 4'd5, 4'd6, 4'd8}) return 1'b1;
        if (op inside {4'd2, 4'd3, 4'd9}) return (k % 2) == 0;
        if (op inside {4'd4, 4'd10}) return k == 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [3:0] op, input int k,
                                               input logic [31:0] w, input logic [31:0] rt);
        logic [31:0] ones, sh;
        logic [7:0]  b;
        logic [15:0] h;
        ones = 32'hFFFF_FFFF;
        sh = w >> (8 * k);
        b = sh[7:0];
        sh = w >> (16 * (k / 2));
        h = sh[15:0];
        case (op)
            4'd0: return {{24{b[7]}}, b};
            4'd1: return {24'h0, b};
            4'd2: return {{16{h[15]}}, h};
            4'd3: return {16'h0, h};
            4'd5: return (w << (8 * (3 - k))) | (rt & (ones >> (8 * (k + 1))));
            4'd6: return (w >> (8 * k)) | (rt & ~(ones >> (8 * k)));
            default: return w;
        endcase
    endfunction

    // Slave model: stalls resp_wait cycles, then returns resp_data.
    always @(negedge clk) begin
        if (reset) begin
            wcnt = 0;
            avm_waitrequest = 1'b0;
        end else if (avm_read || avm_write) begin
            check("bus_allowed", {31'h0, cur_bus}, 32'h1);
            check("bus_read", {31'h0, avm_read}, {31'h0, cur_is_load});
            check("bus_write", {31'h0, avm_write}, {31'h0, ~cur_is_load});
            check("bus_addr", avm_address, cur_addr);
            check("bus_be", {28'h0, avm_byteenable}, {28'h0, cur_be});
            if (!cur_is_load) check("bus_wdata", avm_writedata, cur_wd);
            check("busy_req", {31'h0, busy}, 32'h1);
            if (wcnt < resp_wait) begin
                avm_waitrequest = 1'b1;
                avm_readdata = $urandom;
                wcnt++;
            end else begin
                avm_waitrequest = 1'b0;
                avm_readdata = resp_data;
            end
        end else begin
            wcnt = 0;
            avm_waitrequest = 1'b0;
            avm_readdata = $urandom;
        end
    end

    // Completion monitor.
    always @(negedge clk) begin
        if (!reset) begin
            if (err && !done) check("err_without_done", {31'h0, err}, 32'h0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", {31'h0, done}, 32'h0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("err", {31'h0, err}, {31'h0, e.err});
                    check("load_result", load_result, e.res);
                    check("latency", cyc - e.start_cyc, e.lat);
                    check("bus_idle_at_done", {30'h0, avm_read, avm_write}, 32'h0);
                    check("busy_at_done", {31'h0, busy}, 32'h1);
                end
            end
        end
    end

    task automatic run_txn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                           input logic [31:0] rt, input logic [31:0] w, input int waits);
        exp_t e;
        int   k;
        logic legal;
        int   n;
        @(negedge clk);
        k = int'(a[1:0]);
        legal = model_legal(op, k);
        cur_bus = legal;
        cur_is_load = (op <= 4'd6);
        cur_addr = {a[31:2], 2'b00};
        cur_be = 4'hF;
        cur_wd = sd;
        if (op == 4'd8) begin
            cur_be = 4'b0001 << k;
            cur_wd = {4{sd[7:0]}};
        end else if (op == 4'd9) begin
            cur_be = (k == 0) ? 4'b0011 : 4'b1100;
            cur_wd = {2{sd[15:0]}};
        end
        resp_wait = waits;
        resp_data = w;
        e.start_cyc = cyc;
        if (!legal) begin
            e.err = 1'b1;
            e.lat = 1;
        end else if (waits >= TMO) begin
            e.err = 1'b1;
            e.lat = TMO + 1;
        end else begin
            e.err = 1'b0;
            e.lat = waits + 2;
            if (cur_is_load) model_lr = model_load(op, k, w, rt);
        end
        e.res = model_lr;
        exp_q.push_back(e);
        start = 1'b1;
        mem_op = op;
        addr = a;
        store_data = sd;
        rt_old = rt;
        @(negedge clk);
        // Inputs may change after the start cycle; a start while busy is ignored.
        start = (legal && waits >= 1) ? 1'b1 : 1'b0;
        mem_op = 4'($urandom);
        addr = $urandom;
        store_data = $urandom;
        rt_old = $urandom;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            compared++;
            failed++;
            $display("FAIL done_timeout: no done within bound, expected one");
            exp_q.delete();
        end
    endtask

    initial begin
        #1;
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done_err", {30'h0, done, err}, 32'h0);
        check("rst_rw", {30'h0, avm_read, avm_write}, 32'h0);
        check("rst_load_result", load_result, 32'h0);
        check("rst_addr", avm_address, 32'h0);
        check("rst_wdata", avm_writedata, 32'h0);
        check("rst_be", {28'h0, avm_byteenable}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run_txn(4'd4, 32'h0000_1000, 32'h0, 32'h0, 32'hDEAD_BEEF, 0);
        run_txn(4'd0, 32'h0000_1003, 32'h0, 32'h0, 32'h8011_2233, 3);
        run_txn(4'd1, 32'h0000_1003, 32'h0, 32'h0, 32'h8011_2233, 3);
        run_txn(4'd9, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 32'h0, 0);
        run_txn(4'd5, 32'h0000_3001, 32'h0, 32'hAABB_CCDD, 32'h4433_2211, 1);
        run_txn(4'd6, 32'h0000_3001, 32'h0, 32'hAABB_CCDD, 32'h4433_2211, 2);
        run_txn(4'd4, 32'h0000_1002, 32'h0, 32'h0, 32'h1234_5678, 0);
        run_txn(4'd7, 32'h0000_1000, 32'h0, 32'h0, 32'h1234_5678, 0);
        run_txn(4'd4, 32'h0000_5000, 32'h0, 32'h0, 32'h1111_1111, 100);
        run_txn(4'd10, 32'h0000_6000, 32'hCAFE_F00D, 32'h0, 32'h0, 100);

        for (int i = 0; i < 300; i++) begin
            int waits;
            waits = $urandom_range(0, 3);
            if ($urandom_range(0, 15) == 0) waits = 10;
            run_txn(4'($urandom_range(0, 15)), $urandom, $urandom, $urandom, $urandom, waits);
        end

        // Reset in the middle of a stalled read.
        @(negedge clk);
        cur_bus = 1'b1;
        cur_is_load = 1'b1;
        cur_addr = 32'h0000_4000;
        cur_be = 4'hF;
        resp_wait = 1000;
        start = 1'b1;
        mem_op = 4'd4;
        addr = 32'h0000_4000;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre_reset_read", {31'h0, avm_read}, 32'h1);
        reset = 1'b1;
        #1;
        check("mid_reset_read", {31'h0, avm_read}, 32'h0);
        check("mid_reset_busy", {31'h0, busy}, 32'h0);
        check("mid_reset_done", {31'h0, done}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        model_lr = 32'h0;
        check("post_reset_load_result", load_result, model_lr);
        repeat (6) @(negedge clk);
        check("post_reset_idle", {30'h0, busy, done}, 32'h0);

        run_txn(4'd2, 32'h0000_7002, 32'h0, 32'h0, 32'h8765_4321, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
